// File: rtl/i2c_mem_slave_if.sv
// Status/strobe bundle of the I2C memory slave: memory commit/load strobes and bus state.
`timescale 1ns/1ps
interface i2c_mem_slave_if;
  logic       busy;
  logic       wr_stb;
  logic       rd_stb;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       ack_seen;

  modport slave  (output busy, wr_stb, rd_stb, mem_addr, mem_wdata, ack_seen);
  modport master (input  busy, wr_stb, rd_stb, mem_addr, mem_wdata, ack_seen);
endinterface

// File: rtl/i2c_mem_slave.sv
// I2C slave with a 128x8 register memory, oversampled on clk, no clock stretching.
// Optional macro ADDR_AUTOINC_EN enables multi-byte bursts with a wrapping pointer.
`timescale 1ns/1ps
module i2c_mem_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_DEPTH   = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  inout  wire              sda,
  i2c_mem_slave_if.slave   stat
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, MST_ACK, WAIT_STOP
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [7:0]             r_tx;
  logic [6:0]             r_ptr;
  logic                   r_rw;
  logic                   r_sda_oe;
  logic                   r_busy, r_wr_stb, r_rd_stb, r_ack_seen;
  logic [6:0]             r_mem_addr;
  logic [7:0]             r_mem_wdata;
  logic [7:0]             r_mem [MEM_DEPTH];

  logic       w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [6:0] w_ptr_nxt, w_ld_addr;
  logic [7:0] w_ld_byte;

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  // Our own drive can never be mistaken for a START/STOP.
  assign w_start    = w_scl_s & r_sda_d & ~w_sda_s & ~r_sda_oe;
  assign w_stop     = w_scl_s & ~r_sda_d & w_sda_s & ~r_sda_oe;
  assign w_ptr_nxt  = r_ptr + 7'd1;
  assign w_ld_addr  = (r_state == MST_ACK) ? w_ptr_nxt : r_ptr;
  assign w_ld_byte  = r_mem[w_ld_addr];

  assign sda            = r_sda_oe ? 1'b0 : 1'bz;
  assign stat.busy      = r_busy;
  assign stat.wr_stb    = r_wr_stb;
  assign stat.rd_stb    = r_rd_stb;
  assign stat.mem_addr  = r_mem_addr;
  assign stat.mem_wdata = r_mem_wdata;
  assign stat.ack_seen  = r_ack_seen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_ptr       <= 7'd0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_rd_stb    <= 1'b0;
      r_ack_seen  <= 1'b0;
      r_mem_addr  <= 7'd0;
      r_mem_wdata <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          ADDR, WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda_s};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_oe  <= 1'b1;
              r_bit_cnt <= 4'd0;
              if (r_state == ADDR) begin
                r_ptr   <= r_shift[7:1];
                r_rw    <= r_shift[0];
                r_state <= ACK_ADDR;
              end else begin
                r_mem[r_ptr] <= r_shift;
                r_wr_stb     <= 1'b1;
                r_mem_addr   <= r_ptr;
                r_mem_wdata  <= r_shift;
                r_state      <= ACK_WR;
              end
            end
          end
          ACK_ADDR, MST_ACK: begin
            if (r_state == MST_ACK && w_scl_rise) begin
              r_ack_seen <= ~w_sda_s;
            end else if (w_scl_fall) begin
              if (r_state == ACK_ADDR && !r_rw) begin
                r_sda_oe <= 1'b0;
                r_state  <= WR_DATA;
`ifdef ADDR_AUTOINC_EN
              end else if (r_state == ACK_ADDR || r_ack_seen) begin
`else
              end else if (r_state == ACK_ADDR) begin
`endif
                // Load a byte for transmit and put its MSB on the bus right away.
                r_ptr      <= w_ld_addr;
                r_tx       <= {w_ld_byte[6:0], 1'b0};
                r_sda_oe   <= ~w_ld_byte[7];
                r_rd_stb   <= 1'b1;
                r_mem_addr <= w_ld_addr;
                r_bit_cnt  <= 4'd1;
                r_state    <= RD_DATA;
              end else begin
                r_state <= WAIT_STOP;
              end
            end
          end
          ACK_WR: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
`ifdef ADDR_AUTOINC_EN
              r_ptr     <= w_ptr_nxt;
              r_bit_cnt <= 4'd0;
              r_state   <= WR_DATA;
`else
              r_state   <= WAIT_STOP;
`endif
            end
          end
          RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= MST_ACK;
              end else begin
                r_sda_oe  <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_mem_slave.md
Name: i2c_mem_slave

Overview:
- I2C slave endpoint on the same sda/scl bus as the I2C master; the downstream consumer of its transactions.
- Contains a 128x8 register memory. The 7-bit address field of the first byte indexes the memory directly; the R/W bit selects the direction.
- Write: the next byte is stored at that address. Read: the byte at that address is shifted out.
- Oversamples the bus with the 50 MHz system clock; no clock stretching.

Parameters:
- SYNC_STAGES, 2, flop stages on scl/sda before edge detection (min 2).
- MEM_DEPTH, 128, number of byte locations; index = 7-bit address field.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- scl  input  1  I2C clock from master (slave never drives scl)
- sda  inout  1  open-drain data; driven only 1'b0 or 1'bz
- busy  output  1  high from START detect until STOP detect
- wr_stb  output  1  one-clk pulse when a byte is committed to memory
- rd_stb  output  1  one-clk pulse when a byte is loaded for transmit
- mem_addr  output  7  address of the last committed/loaded byte
- mem_wdata  output  8  last byte written
- ack_seen  output  1  master ACK (0) sampled after the last read byte; held until next read byte

Behaviour:
- Reset (rst=0, async): state=IDLE; sda released (z); busy=0, wr_stb=0, rd_stb=0, mem_addr=0, mem_wdata=0, ack_seen=0; memory cleared to 8'h00; sync flops set to 1.
- Sync: scl_s/sda_s are the SYNC_STAGES-deep synchronised versions. scl_rise/scl_fall are one-clk pulses from scl_s edges.
- START: sda_s falling while scl_s=1. Accepted in any state, including repeated START mid-transfer: goes to ADDR, bit count=0, sda released.
- STOP: sda_s rising while scl_s=1. Accepted in any state: goes to IDLE, sda released, busy=0 on the next clk.
- While the slave itself drives sda, START/STOP detection is masked.
- Bit timing: sample sda_s on scl_rise; change driven sda only on scl_fall. Drive latency ≤ SYNC_STAGES+2 clk after the actual scl fall, well inside the 1.25 us quarter period.
- Byte order: MSB first, 8 data bits then 1 ACK bit.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: shift 8 bits into {addr7, rw}. On the scl_fall after bit 8, drive sda=0 and go to ACK_ADDR. Every address is acknowledged.
  - ACK_ADDR: hold sda=0 through one scl high period; on the next scl_fall:
    - rw=0: release sda, go to WR_DATA.
    - rw=1: load mem[addr7], pulse rd_stb, mem_addr=addr7, drive bit 7, go to RD_DATA.
  - WR_DATA: shift 8 bits. On the scl_fall after bit 8: mem[ptr] <= byte, pulse wr_stb, mem_addr=ptr, mem_wdata=byte, drive sda=0, go to ACK_WR.
  - ACK_WR: hold ACK one scl period; on scl_fall release sda. Go to WR_DATA if ADDR_AUTOINC_EN is defined, else WAIT_STOP.
  - RD_DATA: on each scl_fall drive next bit; a 1 releases sda (z), a 0 drives low. After bit 0's high period, on scl_fall release sda and go to MST_ACK.
  - MST_ACK: on scl_rise sample sda_s; ack_seen = ~sda_s. On the following scl_fall:
    - ACK (0) with autoinc: load the next byte and go to RD_DATA.
    - NACK, or no autoinc: go to WAIT_STOP.
  - WAIT_STOP: sda released; ignore bits, so further written bytes are NACKed; exit only via START or STOP.
- Pointer ptr = addr7 at ACK_ADDR; 7-bit, wraps 127 -> 0.
- A partial byte (START/STOP before bit 8) is discarded, with no memory write and no wr_stb.
- busy=1 from the clk after START detect until the clk after STOP detect.

Optional Feature:
- ADDR_AUTOINC_EN defined: multi-byte burst. After each written byte plus ACK, or each read byte with master ACK, ptr increments (wrap 127->0) and the transfer continues until STOP/START.
- Undefined: exactly one data byte per transaction. Additional write bytes get NACK (sda released); a read proceeds to WAIT_STOP regardless of the master ACK.

Test Plan:
- Write addr 7'h12 data 8'hA5, STOP -> ACK on address and data bits; wr_stb 1 pulse; mem_addr=7'h12; mem_wdata=8'hA5; busy falls after STOP.
- Read addr 7'h12 after the write above, master NACK -> bits 1010_0101 observed on sda; rd_stb 1 pulse; ack_seen=0; IDLE after STOP.
- Read unwritten addr 7'h40 after reset -> 8'h00 returned, address ACKed.
- Write with START at bit 4 of the data byte, then write 7'h05/8'h3C -> no write from the first attempt; mem[7'h05]=8'h3C; wr_stb exactly 1 pulse total.
- rst pulled low mid-read while driving a 0 bit -> sda immediately z; busy=0; memory=0; a subsequent write to 7'h01/8'hFF works.
- ADDR_AUTOINC_EN: write to 7'h7F with bytes 11,22 -> mem[7F]=11, mem[00]=22. Undefined: second byte NACKed, mem[00] stays 00.
